// File: rtl/nec_ir_pkg.sv
// NEC IR receiver shared definitions.
//   - decoder FSM state encoding
//   - default phase-window limits in 50 MHz sys_clk cycles
//   - phase counter width and a window-compare helper
package nec_ir_pkg;

  localparam int CNT_W = 19;

  localparam int unsigned DEF_CNT_056_MIN = 20000;
  localparam int unsigned DEF_CNT_056_MAX = 35000;
  localparam int unsigned DEF_CNT_169_MIN = 80000;
  localparam int unsigned DEF_CNT_169_MAX = 90000;
  localparam int unsigned DEF_CNT_225_MIN = 100000;
  localparam int unsigned DEF_CNT_225_MAX = 125000;
  localparam int unsigned DEF_CNT_45_MIN  = 175000;
  localparam int unsigned DEF_CNT_45_MAX  = 275000;
  localparam int unsigned DEF_CNT_9_MIN   = 400000;
  localparam int unsigned DEF_CNT_9_MAX   = 490000;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    DATA_LOW,
    DATA_HIGH,
    CHECK,
    REPEAT_LOW
  } ir_state_e;

  // Inclusive window test on the phase counter.
  function automatic logic in_win(input logic [CNT_W-1:0] cnt,
                                  input int unsigned       lo,
                                  input int unsigned       hi);
    return (32'(cnt) >= lo) && (32'(cnt) <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_rcv_edge_sync.sv
// ir_edge_sync: brings the asynchronous IR pin into the sys_clk domain and
// produces registered single-cycle rise/fall strobes.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   din   in   raw IR receiver output (idle high)
//   rise  out  one-cycle strobe on a synchronized 0->1 transition
//   fall  out  one-cycle strobe on a synchronized 1->0 transition
module ir_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, hist;

  // Flops reset to the idle-high level so reset release never fakes a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
      rise <= s2 & ~hist;
      fall <= ~s2 & hist;
    end
  end

endmodule

// File: rtl/nec_ir_rcv.sv
// nec_ir_rcv: NEC infrared remote decoder.
// Measures pulse widths of the synchronized IR line, decodes leader, 32-bit
// frame (LSB first: addr, addr_inv, cmd, cmd_inv) and repeat codes.
//   sys_clk    in   50 MHz system clock
//   sys_rst    in   asynchronous active-high reset
//   inf_in     in   IR receiver output, idle high, active low
//   data       out  {12'h000, cmd} of the last valid frame
//   repeat_en  out  one-cycle pulse per valid repeat code
// Build option: define NEC_ADDR_CHECK_EN to also require addr == ~addr_inv
// before a frame is accepted (extended-address frames are then rejected).
module nec_ir_rcv
  import nec_ir_pkg::*;
#(
  parameter int unsigned CNT_056_MIN = DEF_CNT_056_MIN,
  parameter int unsigned CNT_056_MAX = DEF_CNT_056_MAX,
  parameter int unsigned CNT_169_MIN = DEF_CNT_169_MIN,
  parameter int unsigned CNT_169_MAX = DEF_CNT_169_MAX,
  parameter int unsigned CNT_225_MIN = DEF_CNT_225_MIN,
  parameter int unsigned CNT_225_MAX = DEF_CNT_225_MAX,
  parameter int unsigned CNT_45_MIN  = DEF_CNT_45_MIN,
  parameter int unsigned CNT_45_MAX  = DEF_CNT_45_MAX,
  parameter int unsigned CNT_9_MIN   = DEF_CNT_9_MIN,
  parameter int unsigned CNT_9_MAX   = DEF_CNT_9_MAX
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        inf_in,
  output logic [19:0] data,
  output logic        repeat_en
);

  // Without the address check only the last 16 bits shifted in (cmd and
  // cmd_inv) matter, so the shift register is trimmed to those.
`ifdef NEC_ADDR_CHECK_EN
  localparam int SR_W = 32;
`else
  localparam int SR_W = 16;
`endif

  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  ir_state_e        state, state_nxt;
  logic [4:0]       bit_idx;
  logic [SR_W-1:0]  sr;
  logic             frame_valid;

  logic bit_clr, bit_inc, shift_en, shift_bit, frame_ok, rep_hit;
  logic win_056, win_169, win_225, win_45, win_9;
  logic [7:0] cmd, cmd_inv;
  logic       cmd_ok, addr_ok;

  ir_edge_sync u_sync (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (inf_in),
    .rise (rise),
    .fall (fall)
  );

  // Phase counter: restarts on every line edge, saturates so a stuck line
  // still trips the timeout.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)           cnt <= '0;
    else if (rise || fall) cnt <= '0;
    else if (cnt != '1)    cnt <= cnt + 1'b1;
  end

  assign win_056 = in_win(cnt, CNT_056_MIN, CNT_056_MAX);
  assign win_169 = in_win(cnt, CNT_169_MIN, CNT_169_MAX);
  assign win_225 = in_win(cnt, CNT_225_MIN, CNT_225_MAX);
  assign win_45  = in_win(cnt, CNT_45_MIN,  CNT_45_MAX);
  assign win_9   = in_win(cnt, CNT_9_MIN,   CNT_9_MAX);

  assign cmd     = sr[SR_W-9 -: 8];
  assign cmd_inv = sr[SR_W-1 -: 8];
  assign cmd_ok  = (cmd == ~cmd_inv);
`ifdef NEC_ADDR_CHECK_EN
  assign addr_ok = (sr[7:0] == ~sr[15:8]);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    frame_ok  = 1'b0;
    rep_hit   = 1'b0;
    // A phase longer than the longest legal one abandons decoding.
    if (state != IDLE && 32'(cnt) > CNT_9_MAX) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (fall) state_nxt = LEAD_LOW;
        LEAD_LOW:  if (rise) state_nxt = win_9 ? LEAD_HIGH : IDLE;
        LEAD_HIGH: if (fall) begin
          if (win_45) begin
            state_nxt = DATA_LOW;
            bit_clr   = 1'b1;
          end else if (win_225) begin
            state_nxt = REPEAT_LOW;
          end else begin
            state_nxt = IDLE;
          end
        end
        DATA_LOW:  if (rise) state_nxt = win_056 ? DATA_HIGH : IDLE;
        DATA_HIGH: if (fall) begin
          if (win_056 || win_169) begin
            shift_en  = 1'b1;
            shift_bit = win_169;
            bit_inc   = 1'b1;
            state_nxt = (bit_idx == 5'd31) ? CHECK : DATA_LOW;
          end else begin
            state_nxt = IDLE;
          end
        end
        CHECK: begin
          frame_ok  = cmd_ok && addr_ok;
          state_nxt = IDLE;
        end
        REPEAT_LOW: if (rise) begin
          rep_hit   = win_056 && frame_valid;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // LSB-first: each bit enters at the top and walks down.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr          <= '0;
      bit_idx     <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
    end else begin
      repeat_en <= rep_hit;
      if (shift_en) sr <= {shift_bit, sr[SR_W-1:1]};
      if (bit_clr)      bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 1'b1;
      if (frame_ok) begin
        data        <= {12'h000, cmd};
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rcv.sv
`timescale 1ns/1ps
module tb_nec_ir_rcv;

  // Windows scaled down 1000x so full frames fit a short run.
  localparam int unsigned W056_MIN = 20,  W056_MAX = 35;
  localparam int unsigned W169_MIN = 80,  W169_MAX = 90;
  localparam int unsigned W225_MIN = 100, W225_MAX = 125;
  localparam int unsigned W45_MIN  = 175, W45_MAX  = 275;
  localparam int unsigned W9_MIN   = 400, W9_MAX   = 490;
  // Nominal phase lengths in clocks (0.56, 1.69, 2.25, 4.5, 9 ms scaled).
  localparam int T056 = 28, T169 = 85, T225 = 112, T45 = 225, T9 = 450;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        inf_in;
  logic [19:0] data;
  logic        repeat_en;

  int          n_chk = 0, n_pass = 0;
  int          rep_seen = 0, exp_rep = 0;
  logic [19:0] exp_data;
  bit          exp_fv;

  nec_ir_rcv #(
    .CNT_056_MIN(W056_MIN), .CNT_056_MAX(W056_MAX),
    .CNT_169_MIN(W169_MIN), .CNT_169_MAX(W169_MAX),
    .CNT_225_MIN(W225_MIN), .CNT_225_MAX(W225_MAX),
    .CNT_45_MIN (W45_MIN),  .CNT_45_MAX (W45_MAX),
    .CNT_9_MIN  (W9_MIN),   .CNT_9_MAX  (W9_MAX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .inf_in   (inf_in),
    .data     (data),
    .repeat_en(repeat_en)
  );

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (repeat_en) rep_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic hold(input logic lvl, input int n);
    inf_in = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic int jit(input int nom, input int d);
    return nom - d + int'($urandom_range(0, 2 * d));
  endfunction

  // Reference: a frame is accepted when its leader fits the 9 ms window and
  // the command (and, if enabled, the address) byte pairs are complements.
  function automatic bit frame_good(input logic [7:0] a, ai, c, ci, input int lead_low);
    bit need_addr;
    bit ok;
    need_addr = 1'b0;
`ifdef NEC_ADDR_CHECK_EN
    need_addr = 1'b1;
`endif
    ok = (c == ~ci) && (lead_low >= int'(W9_MIN)) && (lead_low <= int'(W9_MAX));
    ok = ok && (!need_addr || (a == ~ai));
    return ok;
  endfunction

  // Sends leader + nbits data bits; a full frame also sends the stop bit and
  // checks data one edge before and on the edge it must update.
  task automatic send_frame(input logic [7:0] a, ai, c, ci, input int lead_low,
                            input int nbits, input string tag);
    logic [31:0] w;
    logic [19:0] old_d;
    w = {ci, c, ai, a};
    hold(1'b0, lead_low);
    hold(1'b1, jit(T45, 20));
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, jit(T056, 3));
      hold(1'b1, w[i] ? jit(T169, 2) : jit(T056, 3));
    end
    if (nbits == 32) begin
      old_d = exp_data;
      if (frame_good(a, ai, c, ci, lead_low)) begin
        exp_data = {12'h000, c};
        exp_fv   = 1'b1;
      end
      inf_in = 1'b0;
      repeat (4) @(posedge sys_clk);
      #1 chk({tag, "_pre"}, data, old_d);
      @(posedge sys_clk);
      #1 chk({tag, "_data"}, data, exp_data);
      hold(1'b0, jit(T056, 3) - 5);
      hold(1'b1, 1);
    end
  endtask

  // Repeat code; the pulse must land exactly on the 4th edge after the rise.
  task automatic send_repeat(input string tag);
    hold(1'b0, jit(T9, 20));
    hold(1'b1, jit(T225, 5));
    hold(1'b0, jit(T056, 3));
    inf_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 chk({tag, "_pre"}, repeat_en, 0);
    @(posedge sys_clk);
    #1 chk({tag, "_pulse"}, repeat_en, exp_fv);
    @(posedge sys_clk);
    #1 chk({tag, "_post"}, repeat_en, 0);
    if (exp_fv) exp_rep++;
    hold(1'b1, 20);
  endtask

  initial begin
    logic [7:0] a, ai, c, ci, flip;
    int         ll;
    sys_rst  = 1'b1;
    inf_in   = 1'b1;
    exp_data = '0;
    exp_fv   = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_data", data, 0);
    chk("rst_rep", repeat_en, 0);
    sys_rst = 1'b0;

    hold(1'b1, 50);
    chk("idle_data", data, 0);
    chk("idle_rep", rep_seen, 0);

    send_frame(8'h57, 8'hA8, 8'h22, 8'hDD, T9, 32, "f22");
    hold(1'b1, 2100);
    send_repeat("rep1");
    hold(1'b1, 200);
    chk("rep1_cnt", rep_seen, exp_rep);
    chk("rep1_data", data, 20'h00022);

    send_frame(8'h57, 8'hA8, 8'h35, 8'h35, T9, 32, "badinv");
    hold(1'b1, 300);
    chk("badinv_data", data, 20'h00022);
    chk("badinv_rep", rep_seen, exp_rep);

    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 250, 32, "shortlead");
    hold(1'b1, 300);
    chk("short_data", data, 20'h00022);
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, T9, 32, "f45");
    hold(1'b1, 300);
    chk("f45_data", data, 20'h00045);

    // Repeat right after reset: no frame has been accepted yet.
    sys_rst = 1'b1;
    hold(1'b1, 3);
    chk("rst2_data", data, 0);
    sys_rst  = 1'b0;
    exp_data = '0;
    exp_fv   = 1'b0;
    hold(1'b1, 50);
    send_repeat("rep_rst");
    hold(1'b1, 200);
    chk("rep_rst_cnt", rep_seen, exp_rep);

    // Reset in the middle of bit 12 after a good frame.
    send_frame(8'h10, 8'hEF, 8'h99, 8'h66, T9, 32, "f99");
    hold(1'b1, 300);
    send_frame(8'h10, 8'hEF, 8'h12, 8'hED, T9, 12, "part");
    hold(1'b0, 10);
    sys_rst = 1'b1;
    #1 chk("mid_rst_data", data, 0);
    chk("mid_rst_rep", repeat_en, 0);
    inf_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst  = 1'b0;
    exp_data = '0;
    exp_fv   = 1'b0;
    hold(1'b1, 100);
    send_frame(8'h10, 8'hEF, 8'h5A, 8'hA5, T9, 32, "f5a");
    hold(1'b1, 300);
    send_repeat("rep_after");
    hold(1'b1, 200);
    chk("rep_after_cnt", rep_seen, exp_rep);

    // Randomized frames against the reference model.
    for (int k = 0; k < 5; k++) begin
      a    = 8'($urandom);
      ai   = ($urandom_range(0, 3) != 0) ? ~a : 8'($urandom);
      c    = 8'($urandom);
      flip = 8'h01 << $urandom_range(0, 7);
      ci   = ($urandom_range(0, 3) != 0) ? ~c : (~c ^ flip);
      ll   = jit(T9, 20);
      send_frame(a, ai, c, ci, ll, 32, $sformatf("rnd%0d", k));
      hold(1'b1, 300);
      if ($urandom_range(0, 1) == 1) send_repeat($sformatf("rnd%0d_rep", k));
      hold(1'b1, 200);
      chk($sformatf("rnd%0d_data", k), data, exp_data);
      chk($sformatf("rnd%0d_repcnt", k), rep_seen, exp_rep);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
